// File: rtl/opstage_pkg.sv
// Shared types and constants for the ID operand stage.
// Branch encodings, br_t, default widths and a branch-resolve helper.
package opstage_pkg;

  typedef logic [1:0] br_t;

  localparam br_t BR_NONE   = 2'b00;
  localparam br_t BR_ALWAYS = 2'b01;
  localparam br_t BR_EQZ    = 2'b10;
  localparam br_t BR_NEZ    = 2'b11;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_CTRL_W  = 8;
  localparam int DEF_NUM_FWD = 3;

  function automatic logic br_resolve(
    input br_t  br,
    input logic op_zero
  );
    logic tk;
    case (br)
      BR_ALWAYS: tk = 1'b1;
      BR_EQZ:    tk = op_zero;
      BR_NEZ:    tk = !op_zero;
      default:   tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/opstage_fwd_sel.sv
// Per-operand source select: nearest matching forward source or RF data.
// Ports: re_i/ra_i/dflt_i operand request, fwd_* buses, rf_rdata_i -> data_o, hazard_o.
// OPSTAGE_BYPASS_EN defined: forward data used, hazard only on pending source.
// Undefined: RF data only, any forward match is a hazard.
module opstage_fwd_sel
  import opstage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic                       re_i,
  input  logic [RADDR_W-1:0]         ra_i,
  input  logic [DATA_W-1:0]          dflt_i,
  input  logic [NUM_FWD-1:0]         fwd_we_i,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
  input  logic [NUM_FWD-1:0]         fwd_pend_i,
  input  logic [DATA_W-1:0]          rf_rdata_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       hazard_o
);

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              hit_pend;

  // First match from index 0 wins: the youngest producer.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_pend = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_we_i[i] &&
          fwd_waddr_i[i*RADDR_W +: RADDR_W] == ra_i) begin
        hit      = 1'b1;
        hit_data = fwd_wdata_i[i*DATA_W +: DATA_W];
        hit_pend = fwd_pend_i[i];
      end
    end
  end

`ifdef OPSTAGE_BYPASS_EN
  assign data_o   = !re_i ? dflt_i
                  : (hit ? hit_data : rf_rdata_i);
  assign hazard_o = re_i && hit && hit_pend;
`else
  // Wait until the producer has retired through a write-first RF.
  assign data_o   = re_i ? rf_rdata_i : dflt_i;
  assign hazard_o = re_i && hit;

  logic unused_fwd;
  assign unused_fwd = ^{hit_data, hit_pend};
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: operand read/forward, hazard stall, branch resolve, ID/EX slot.
// Ports: in_* decoded instr, rf_* RF read, fwd_* bypass, out_* slot, br_* redirect, stall_cnt.
// Macro OPSTAGE_BYPASS_EN enables full forwarding (see opstage_fwd_sel).
module id_operand_stage
  import opstage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       in_re0,
  input  logic                       in_re1,
  input  logic [RADDR_W-1:0]         in_ra0,
  input  logic [RADDR_W-1:0]         in_ra1,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic                       in_we,
  input  logic [RADDR_W-1:0]         in_waddr,
  input  br_t                        in_br,
  output logic [RADDR_W-1:0]         rf_raddr0,
  output logic [RADDR_W-1:0]         rf_raddr1,
  input  logic [DATA_W-1:0]          rf_rdata0,
  input  logic [DATA_W-1:0]          rf_rdata1,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
  input  logic [NUM_FWD-1:0]         fwd_pend,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_op0,
  output logic [DATA_W-1:0]          out_op1,
  output logic                       out_we,
  output logic [RADDR_W-1:0]         out_waddr,
  output logic                       br_taken,
  output logic [ADDR_W-1:0]          br_target,
  output logic [15:0]                stall_cnt
);

  logic [DATA_W-1:0]  op0, op1;
  logic               haz0, haz1, hazard;
  logic               accept;
  logic               taken_d;
  logic [ADDR_W-1:0]  imm_a, target_d;
  logic [15:0]        stall_d;

  logic               valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [DATA_W-1:0]  op0_q, op1_q;
  logic               we_q;
  logic [RADDR_W-1:0] waddr_q;
  logic               taken_q;
  logic [ADDR_W-1:0]  target_q;
  logic [15:0]        stall_q;

  assign rf_raddr0 = in_ra0;
  assign rf_raddr1 = in_ra1;

  opstage_fwd_sel #(
    .DATA_W (DATA_W),
    .RADDR_W(RADDR_W),
    .NUM_FWD(NUM_FWD)
  ) u_sel0 (
    .re_i       (in_re0),
    .ra_i       (in_ra0),
    .dflt_i     ('0),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_pend_i (fwd_pend),
    .rf_rdata_i (rf_rdata0),
    .data_o     (op0),
    .hazard_o   (haz0)
  );

  opstage_fwd_sel #(
    .DATA_W (DATA_W),
    .RADDR_W(RADDR_W),
    .NUM_FWD(NUM_FWD)
  ) u_sel1 (
    .re_i       (in_re1),
    .ra_i       (in_ra1),
    .dflt_i     (in_imm),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_pend_i (fwd_pend),
    .rf_rdata_i (rf_rdata1),
    .data_o     (op1),
    .hazard_o   (haz1)
  );

  assign hazard   = haz0 || haz1;
  assign in_ready = !rst && !hazard && !flush &&
                    (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Immediate is a signed word offset; target wraps in ADDR_W.
  assign imm_a    = ADDR_W'($signed(in_imm));
  assign target_d = in_pc + imm_a + ADDR_W'(1);
  assign taken_d  = accept && br_resolve(in_br, op0 == '0);

  assign stall_d  = (in_valid && hazard && stall_q != 16'hFFFF)
                  ? stall_q + 16'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ctrl_q   <= '0;
      op0_q    <= '0;
      op1_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      stall_q  <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) begin
        pc_q    <= in_pc;
        ctrl_q  <= in_ctrl;
        op0_q   <= op0;
        op1_q   <= op1;
        we_q    <= in_we;
        waddr_q <= in_waddr;
      end
      taken_q <= taken_d;
      if (taken_d) target_q <= target_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_ctrl  = ctrl_q;
  assign out_op0   = op0_q;
  assign out_op1   = op1_q;
  assign out_we    = we_q;
  assign out_waddr = waddr_q;
  assign br_taken  = taken_q;
  assign br_target = target_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: random + directed stimulus,
// reference model of operand/hazard/branch rules, queue-based checking.
module tb_id_operand_stage;
  import opstage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int PW = 16;
  localparam int CW = 8;
  localparam int NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush, in_valid, in_ready;
  logic [PW-1:0]  in_pc;
  logic [CW-1:0]  in_ctrl;
  logic           in_re0, in_re1;
  logic [AW-1:0]  in_ra0, in_ra1;
  logic [DW-1:0]  in_imm;
  logic           in_we;
  logic [AW-1:0]  in_waddr;
  br_t            in_br;
  logic [AW-1:0]  rf_raddr0, rf_raddr1;
  logic [DW-1:0]  rf_rdata0, rf_rdata1;
  logic [NF-1:0]  fwd_we, fwd_pend;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic           out_valid, out_ready;
  logic [PW-1:0]  out_pc;
  logic [CW-1:0]  out_ctrl;
  logic [DW-1:0]  out_op0, out_op1;
  logic           out_we;
  logic [AW-1:0]  out_waddr;
  logic           br_taken;
  logic [PW-1:0]  br_target;
  logic [15:0]    stall_cnt;

  logic [DW-1:0] rf [16];
  logic [AW-1:0] fwa [NF];
  logic [DW-1:0] fwd [NF];

  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  always_comb begin
    fwd_waddr = '0;
    fwd_wdata = '0;
    for (int i = 0; i < NF; i++) begin
      fwd_waddr[i*AW +: AW] = fwa[i];
      fwd_wdata[i*DW +: DW] = fwd[i];
    end
  end

  id_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_re0(in_re0), .in_re1(in_re1),
    .in_ra0(in_ra0), .in_ra1(in_ra1),
    .in_imm(in_imm), .in_we(in_we),
    .in_waddr(in_waddr), .in_br(in_br),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_op0(out_op0), .out_op1(out_op1),
    .out_we(out_we), .out_waddr(out_waddr),
    .br_taken(br_taken), .br_target(br_target),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [PW-1:0] pc;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] op0;
    logic [DW-1:0] op1;
    logic          we;
    logic [AW-1:0] waddr;
  } txn_t;

  txn_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  bit m_valid = 0;
  bit prev_taken = 0;
  logic [PW-1:0] prev_target = '0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Operand rule: disabled -> default; else youngest matching source or RF.
  task automatic resolve(input logic re, input logic [AW-1:0] ra,
                         input logic [DW-1:0] dflt,
                         output logic [DW-1:0] val, output bit haz);
    int hit;
    hit = -1;
    val = dflt;
    haz = 0;
    if (re) begin
      for (int i = NF - 1; i >= 0; i--)
        if (fwd_we[i] && fwa[i] == ra) hit = i;
`ifdef OPSTAGE_BYPASS_EN
      val = (hit >= 0) ? fwd[hit] : rf[ra];
      haz = (hit >= 0) && fwd_pend[hit];
`else
      val = rf[ra];
      haz = (hit >= 0);
`endif
    end
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_pc = '0; in_ctrl = '0; in_re0 = 0; in_re1 = 0;
    in_ra0 = '0; in_ra1 = '0; in_imm = '0; in_we = 0;
    in_waddr = '0; in_br = BR_NONE;
    fwd_we = '0; fwd_pend = '0;
    for (int i = 0; i < NF; i++) begin
      fwa[i] = '0;
      fwd[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's combinational outputs and advance the model.
  task automatic eval();
    logic [DW-1:0] v0, v1;
    bit h0, h1, haz, rdy, acc, tk;
    txn_t t;
    @(negedge clk);
    #1;
    if (rst) begin
      chk("in_ready_rst", in_ready, 0);
      sbq.delete();
      m_valid = 0;
      prev_taken = 0;
      m_cnt = 0;
      return;
    end
    chk("br_taken", br_taken, prev_taken);
    if (prev_taken) chk("br_target", br_target, prev_target);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("out_valid", out_valid, m_valid);
    chk("rf_raddr0", rf_raddr0, in_ra0);
    chk("rf_raddr1", rf_raddr1, in_ra1);
    resolve(in_re0, in_ra0, '0, v0, h0);
    resolve(in_re1, in_ra1, in_imm, v1, h1);
    haz = h0 || h1;
    rdy = !haz && (!m_valid || out_ready) && !flush;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (in_valid && haz && m_cnt < 65535) m_cnt++;
    tk = acc && (in_br == BR_ALWAYS ||
                 (in_br == BR_EQZ && v0 == 0) ||
                 (in_br == BR_NEZ && v0 != 0));
    prev_taken = tk;
    if (tk) prev_target = PW'(in_pc + in_imm + 16'd1);
    if (flush) begin
      if (m_valid && sbq.size() > 0) void'(sbq.pop_front());
      m_valid = 0;
    end else if (acc) begin
      t.pc = in_pc; t.ctrl = in_ctrl; t.op0 = v0; t.op1 = v1;
      t.we = in_we; t.waddr = in_waddr;
      sbq.push_back(t);
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  // Monitor: presented slot must equal the oldest expected entry.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          t = sbq[0];
          chk("out_pc", out_pc, t.pc);
          chk("out_ctrl", out_ctrl, t.ctrl);
          chk("out_op0", out_op0, t.op0);
          chk("out_op1", out_op1, t.op1);
          chk("out_we", out_we, t.we);
          chk("out_waddr", out_waddr, t.waddr);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic rand_in();
    idle();
    in_valid = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 9) < 7);
    flush = ($urandom_range(0, 19) == 0);
    if (flush) out_ready = 0;
    in_pc = PW'($urandom);
    in_ctrl = CW'($urandom);
    in_imm = DW'($urandom);
    in_re0 = $urandom_range(0, 3) != 0;
    in_re1 = $urandom_range(0, 1);
    in_ra0 = AW'($urandom_range(0, 5));
    in_ra1 = AW'($urandom_range(0, 5));
    in_we = $urandom_range(0, 1);
    in_waddr = AW'($urandom);
    in_br = br_t'($urandom_range(0, 3));
    for (int i = 0; i < NF; i++) begin
      fwd_we[i] = ($urandom_range(0, 3) == 0);
      fwd_pend[i] = ($urandom_range(0, 3) == 0);
      fwa[i] = AW'($urandom_range(0, 5));
      fwd[i] = DW'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      rf[i] = (i % 4 == 0) ? '0 : DW'($urandom);
    idle();
    rst = 1;
    repeat (2) begin tick(); idle(); rst = 1; eval(); end
    tick(); idle(); eval();
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_op0", out_op0, 0);
    chk("rst_out_op1", out_op1, 0);
    chk("rst_br_target", br_target, 0);

    // R3 from RF on both operands
    rf[3] = 16'h1234;
    tick(); idle(); in_valid = 1; in_pc = 16'h0100;
    in_re0 = 1; in_re1 = 1; in_ra0 = 3; in_ra1 = 3; eval();
    tick(); idle(); eval();

    // Two sources write R3; youngest wins (or stall without bypass)
    tick(); idle(); in_valid = 1; in_re0 = 1; in_ra0 = 3;
    fwd_we = 3'b101; fwa[0] = 3; fwd[0] = 16'hAAAA;
    fwa[2] = 3; fwd[2] = 16'h5555; eval();
    tick(); idle(); eval();

    // Pending load on fwd0 for two cycles, then data ready
    for (int c = 0; c < 3; c++) begin
      tick(); idle(); in_valid = 1; in_re0 = 1; in_ra0 = 3;
      fwd_we[0] = 1; fwa[0] = 3; fwd[0] = 16'hBEEF;
      fwd_pend[0] = (c < 2); eval();
    end
    tick(); idle(); eval();

    // BEQZ taken / not taken with negative offset
    rf[5] = 16'h0000; rf[6] = 16'h0001;
    for (int c = 0; c < 2; c++) begin
      tick(); idle(); in_valid = 1; in_re0 = 1;
      in_ra0 = (c == 0) ? 4'd5 : 4'd6;
      in_br = BR_EQZ; in_pc = 16'h0010; in_imm = 16'hFFFE; eval();
      tick(); idle(); eval();
    end

    // Backpressure hold, then flush
    tick(); idle(); in_valid = 1; in_pc = 16'h0200; in_ctrl = 8'h5A;
    out_ready = 0; eval();
    for (int c = 0; c < 3; c++) begin
      tick(); idle(); in_valid = 1; in_pc = 16'h0300; out_ready = 0; eval();
    end
    tick(); idle(); flush = 1; out_ready = 0; in_valid = 1; eval();
    tick(); idle(); eval();

    // fwd1 R2 not pending, held two cycles then dropped
    rf[2] = 16'h2222;
    for (int c = 0; c < 3; c++) begin
      tick(); idle(); in_valid = 1; in_re1 = 1; in_ra1 = 2;
      fwd_we[1] = (c < 2); fwa[1] = 2; fwd[1] = 16'h7777; eval();
    end
    tick(); idle(); eval();

    // Random traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      tick(); rand_in();
      if (c == 1500) begin rst = 1; out_ready = 0; end
      eval();
    end

    repeat (4) begin tick(); idle(); eval(); end
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side operand stage sitting between the instruction decoder and EX. It takes decoded fields, reads the register file, resolves operands by forwarding from any number of later pipeline stages, detects load-use and RAW hazards, and resolves PC-relative branches. Results land in a registered ID/EX pipeline slot with valid/ready handshake.

## Interface

Parameters:
- DATA_W, 16, datapath width
- RADDR_W, 4, register address width (general plus special registers SP/IH/T/RA)
- ADDR_W, 16, PC width (word addressed)
- CTRL_W, 8, opaque decoded ALU sel/op bundle passed to EX
- NUM_FWD, 3, forwarding sources, index 0 = nearest (EX)

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  kill in-flight slot
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle
- in_pc  in  ADDR_W  PC of instruction
- in_ctrl  in  CTRL_W  decoded control
- in_re0, in_re1  in  1 each  operand read enables
- in_ra0, in_ra1  in  RADDR_W each  operand register addresses
- in_imm  in  DATA_W  sign/zero-extended immediate
- in_we  in  1  instruction writes a register
- in_waddr  in  RADDR_W  destination
- in_br  in  2  branch type: 00 none, 01 always, 10 eqz, 11 nez
- rf_raddr0, rf_raddr1  out  RADDR_W each  RF read addresses (= in_ra0/in_ra1)
- rf_rdata0, rf_rdata1  in  DATA_W each  RF combinational read data
- fwd_we  in  NUM_FWD  source holds a pending write
- fwd_waddr  in  NUM_FWD*RADDR_W  packed destinations
- fwd_wdata  in  NUM_FWD*DATA_W  packed data
- fwd_pend  in  NUM_FWD  data not yet available (load in flight)
- out_valid  out  1  slot valid
- out_ready  in  1  EX accepts
- out_pc, out_ctrl, out_op0, out_op1, out_we, out_waddr  out  matching widths  registered slot
- br_taken  out  1  one-cycle redirect pulse
- br_target  out  ADDR_W  redirect address
- stall_cnt  out  16  saturating hazard-stall cycle count

## Operation

- Operand n: if in_ren=0, op0 = 0, op1 = in_imm. Otherwise the lowest index i with fwd_we[i] and fwd_waddr[i]==in_ran supplies data; if none, rf_rdatan.
- Hazard: a selected source with fwd_pend set. A hazard holds in_ready low; no transfer.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): slot loads all fields, out_valid=1.
- Drain without accept: out_valid && out_ready clears out_valid.
- flush: out_valid cleared next cycle, overriding acceptance. Same-cycle input is dropped (in_ready=0).
- Branch on accept: taken if in_br=01, or 10 with op0==0, or 11 with op0!=0. On taken, br_taken=1 for exactly one cycle with br_target = in_pc + 1 + in_imm, truncated to ADDR_W (wraps).
- The delay-slot instruction is accepted normally. Fetch redirect belongs to upstream.
- stall_cnt increments on every cycle with in_valid && hazard. It saturates at 0xFFFF.

## Timing

- Latency 1 cycle input-to-slot. Forward selection, hazard detection and the branch compare are combinational in the accept cycle.
- br_taken/br_target are registered and assert the cycle after accept, coincident with out_valid.
- Reset values: out_valid=0, out_pc/out_ctrl/out_op0/out_op1/out_waddr=0, out_we=0, br_taken=0, br_target=0, stall_cnt=0.
- in_ready during rst = 0.
- Reset mid-stall discards everything.
- out_* remain stable while out_valid && !out_ready.
- br_taken is never asserted by a flushed cycle's acceptance.

## Configuration

- OPSTAGE_BYPASS_EN defined: full forwarding as above.
- Undefined: operands come only from rf_rdata. Any fwd_we[i] match on an enabled operand is a hazard, regardless of fwd_pend.
- The fwd ports must then include WB, and the RF must be write-first.

## Structure

- Package opstage_pkg: BR_NONE/BR_ALWAYS/BR_EQZ/BR_NEZ constants, the br_t type, and default widths.
- Sub-module opstage_fwd_sel, instantiated twice:
  - Inputs: one operand's address and read enable, the fwd buses, RF data.
  - Outputs: operand data and hazard bit.

## Test plan

- RF R3=0x1234, no fwd, ADDU R3,R3 accepted -> next cycle out_valid=1, out_op0=out_op1=0x1234.
- fwd0 and fwd2 both write R3 (0xAAAA, 0x5555), read R3 -> out_op0=0xAAAA.
- fwd0 R3 with fwd_pend=1 for 2 cycles -> in_ready=0 for 2 cycles, stall_cnt=2, then op from fwd0.
- BEQZ, op0=0, pc=0x0010, imm=0xFFFE -> br_taken pulse, br_target=0x000F. Same with op0=1 -> no pulse.
- out_ready=0 with slot full -> in_ready=0, out_* stable. Then flush -> out_valid=0 next cycle.
- Without OPSTAGE_BYPASS_EN, fwd1 R2 not pending -> stall until fwd_we[1] drops, then RF value.
